// File: rtl/dual_store_responder.sv
// ---------------------------------------------------------------------------
// dual_store_responder
//
// Data-memory responder for the dual-issue (ODD/EVEN) pipeline.
//   * Accepts up to two stores per cycle (ODD first, then EVEN) into an
//     in-order store buffer of SB_DEPTH entries.
//   * Retires one store per cycle from the buffer head into a single-write
//     word RAM.
//   * Serves both load ports combinationally, forwarding the youngest
//     matching buffered store; the EVEN port additionally sees a same-cycle
//     ODD store to the same word.
//   * Raises stall when fewer than two free entries remain, so a full pair
//     can always be accepted without overflow.
//
// Ports
//   clk            system clock, all state on rising edge
//   reset          synchronous, active-high; discards pending stores
//   memwriteODD    ODD-slot store request (older instruction of the pair)
//   dataadrODD     ODD byte address (word index = adr[IDX_W+1:2])
//   writedataODD   ODD store data
//   memwriteEVEN   EVEN-slot store request (younger instruction)
//   dataadrEVEN    EVEN byte address
//   writedataEVEN  EVEN store data
//   readdataODD    load data for dataadrODD (combinational)
//   readdataEVEN   load data for dataadrEVEN (combinational)
//   stall          1 = stores presented this cycle are not accepted
//   sb_count       number of occupied buffer entries
//   sb_empty       buffer holds no entries
// ---------------------------------------------------------------------------
module dual_store_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int SB_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        memwriteODD,
    input  logic [31:0]                 dataadrODD,
    input  logic [31:0]                 writedataODD,
    input  logic                        memwriteEVEN,
    input  logic [31:0]                 dataadrEVEN,
    input  logic [31:0]                 writedataEVEN,
    output logic [31:0]                 readdataODD,
    output logic [31:0]                 readdataEVEN,
    output logic                        stall,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_empty
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Address decode: only the word index matters; higher bits alias.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] idxOdd;
    logic [IDX_W-1:0] idxEven;
    logic             unusedAdrBits;

    assign idxOdd  = dataadrODD[IDX_W+1:2];
    assign idxEven = dataadrEVEN[IDX_W+1:2];
    assign unusedAdrBits = ^{dataadrODD[31:IDX_W+2], dataadrODD[1:0],
                             dataadrEVEN[31:IDX_W+2], dataadrEVEN[1:0]};

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]      ram    [DEPTH_WORDS];
    logic [IDX_W-1:0] sbIdx  [SB_DEPTH];
    logic [31:0]      sbData [SB_DEPTH];

    logic [PTR_W-1:0] headPtrReg;
    logic [PTR_W-1:0] headPtrNext;
    logic [PTR_W-1:0] tailPtrReg;
    logic [PTR_W-1:0] tailPtrNext;
    logic [CNT_W-1:0] countReg;
    logic [CNT_W-1:0] countNext;

    // ------------------------------------------------------------------
    // Push / pop control
    // ------------------------------------------------------------------
    logic             pushOdd;
    logic             pushEven;
    logic             doPop;
    logic [CNT_W-1:0] pushCount;
    logic [PTR_W-1:0] evenSlot;

    // Stalling at SB_DEPTH-1 leaves at least two free slots whenever a
    // pair is accepted, even if no pop happens that cycle.
    assign stall    = (countReg >= CNT_W'(SB_DEPTH - 1));
    assign pushOdd  = memwriteODD  && !stall;
    assign pushEven = memwriteEVEN && !stall;
    assign doPop    = (countReg != '0);

    assign pushCount = CNT_W'(pushOdd) + CNT_W'(pushEven);
    // EVEN lands right behind ODD when both push, otherwise at the tail.
    assign evenSlot  = tailPtrReg + PTR_W'(pushOdd);

    assign countNext   = countReg + pushCount - CNT_W'(doPop);
    assign headPtrNext = headPtrReg + PTR_W'(doPop);
    assign tailPtrNext = tailPtrReg + pushCount[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            headPtrReg <= '0;
            tailPtrReg <= '0;
            countReg   <= '0;
        end else begin
            headPtrReg <= headPtrNext;
            tailPtrReg <= tailPtrNext;
            countReg   <= countNext;
        end
    end

    // Buffer payload needs no reset: occupancy alone decides validity.
    // The two push slots are always distinct and never the head entry,
    // because a push only happens with at least two free slots.
    always_ff @(posedge clk) begin
        if (pushOdd) begin
            sbIdx[tailPtrReg]  <= idxOdd;
            sbData[tailPtrReg] <= writedataODD;
        end
        if (pushEven) begin
            sbIdx[evenSlot]  <= idxEven;
            sbData[evenSlot] <= writedataEVEN;
        end
    end

    // Retire into RAM. A reset cycle discards the head instead of writing it.
    always_ff @(posedge clk) begin
        if (!reset && doPop) begin
            ram[sbIdx[headPtrReg]] <= sbData[headPtrReg];
        end
    end

    // ------------------------------------------------------------------
    // Per-slot validity and address match
    // ------------------------------------------------------------------
    logic [SB_DEPTH-1:0] entryValid;
    logic [SB_DEPTH-1:0] matchOdd;
    logic [SB_DEPTH-1:0] matchEven;

    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] age;
            // Distance from head; the slot is live if it lies inside the
            // occupied window [head, head+count).
            assign age            = PTR_W'(gi) - headPtrReg;
            assign entryValid[gi] = (CNT_W'(age) < countReg);
            assign matchOdd[gi]   = entryValid[gi] && (sbIdx[gi] == idxOdd);
            assign matchEven[gi]  = entryValid[gi] && (sbIdx[gi] == idxEven);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Youngest-match forwarding: scan oldest to youngest, last hit wins.
    // ------------------------------------------------------------------
    logic             fwdOddHit;
    logic [31:0]      fwdOddData;
    logic             fwdEvenHit;
    logic [31:0]      fwdEvenData;
    logic [PTR_W-1:0] scanSlot;

    always_comb begin
        fwdOddHit   = 1'b0;
        fwdOddData  = '0;
        fwdEvenHit  = 1'b0;
        fwdEvenData = '0;
        scanSlot    = headPtrReg;
        for (int k = 0; k < SB_DEPTH; k++) begin
            scanSlot = headPtrReg + PTR_W'(k);
            if (matchOdd[scanSlot]) begin
                fwdOddHit  = 1'b1;
                fwdOddData = sbData[scanSlot];
            end
            if (matchEven[scanSlot]) begin
                fwdEvenHit  = 1'b1;
                fwdEvenData = sbData[scanSlot];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load ports
    // ------------------------------------------------------------------
    // The EVEN load is younger than the ODD store of the same pair, so it
    // must observe that store even when the pair is being held by stall.
    // The ODD load is older than the EVEN store and never sees it.
    always_comb begin
        if (memwriteODD && (idxOdd == idxEven)) begin
            readdataEVEN = writedataODD;
        end else if (fwdEvenHit) begin
            readdataEVEN = fwdEvenData;
        end else begin
            readdataEVEN = ram[idxEven];
        end
    end

    always_comb begin
        if (fwdOddHit) begin
            readdataODD = fwdOddData;
        end else begin
            readdataODD = ram[idxOdd];
        end
    end

    assign sb_count = countReg;
    assign sb_empty = (countReg == '0);

endmodule

// File: tb/tb_dual_store_responder.sv
// ---------------------------------------------------------------------------
// tb_dual_store_responder
//
// Self-checking bench for dual_store_responder. A reference model keeps a
// FIFO queue of pending stores and a plain word array for memory; every
// cycle it predicts stall, occupancy and both load results, and all
// comparisons go through checkVal.
// ---------------------------------------------------------------------------
module tb_dual_store_responder;

    localparam int DW = 64;
    localparam int SB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwriteODD;
    logic [31:0] dataadrODD;
    logic [31:0] writedataODD;
    logic        memwriteEVEN;
    logic [31:0] dataadrEVEN;
    logic [31:0] writedataEVEN;
    logic [31:0] readdataODD;
    logic [31:0] readdataEVEN;
    logic        stall;
    logic [2:0]  sb_count;
    logic        sb_empty;

    always #5 clk = ~clk;

    dual_store_responder #(
        .DEPTH_WORDS (DW),
        .SB_DEPTH    (SB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .memwriteODD   (memwriteODD),
        .dataadrODD    (dataadrODD),
        .writedataODD  (writedataODD),
        .memwriteEVEN  (memwriteEVEN),
        .dataadrEVEN   (dataadrEVEN),
        .writedataEVEN (writedataEVEN),
        .readdataODD   (readdataODD),
        .readdataEVEN  (readdataEVEN),
        .stall         (stall),
        .sb_count      (sb_count),
        .sb_empty      (sb_empty)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int compared   = 0;
    int mismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          idx;
        logic [31:0] data;
    } entry_t;

    entry_t      pendQ[$];
    logic [31:0] modelMem [DW];
    bit          memKnown [DW];

    bit          curRst;
    bit          curMwo;
    bit          curMwe;
    bit          curStall;
    logic [31:0] curAo, curWo, curAe, curWe;

    function automatic int wordOf(input logic [31:0] adr);
        return int'((adr >> 2) % DW);
    endfunction

    // Newest pending store to the word wins, else memory (if known).
    task automatic modelLoad(input int idx, output bit known, output logic [31:0] val);
        known = 1'b0;
        val   = '0;
        for (int k = 0; k < pendQ.size(); k++) begin
            if (pendQ[k].idx == idx) begin
                known = 1'b1;
                val   = pendQ[k].data;
            end
        end
        if (!known && memKnown[idx]) begin
            known = 1'b1;
            val   = modelMem[idx];
        end
    endtask

    task automatic applyAndCheck(input bit rst,
                                 input bit mwo, input logic [31:0] ao, input logic [31:0] wo,
                                 input bit mwe, input logic [31:0] ae, input logic [31:0] we);
        bit          known;
        logic [31:0] v;
        reset = rst; memwriteODD = mwo; dataadrODD = ao; writedataODD = wo;
        memwriteEVEN = mwe; dataadrEVEN = ae; writedataEVEN = we;
        curRst = rst; curMwo = mwo; curAo = ao; curWo = wo;
        curMwe = mwe; curAe = ae; curWe = we;
        #1;
        curStall = (pendQ.size() >= SB - 1);
        checkVal("stall",    {31'b0, stall},    {31'b0, curStall});
        checkVal("sb_count", 32'(sb_count),     32'(pendQ.size()));
        checkVal("sb_empty", {31'b0, sb_empty}, {31'b0, (pendQ.size() == 0)});
        modelLoad(wordOf(ao), known, v);
        if (known) checkVal("readdataODD", readdataODD, v);
        if (mwo && (wordOf(ao) == wordOf(ae))) begin
            known = 1'b1;
            v     = wo;
        end else begin
            modelLoad(wordOf(ae), known, v);
        end
        if (known) checkVal("readdataEVEN", readdataEVEN, v);
    endtask

    task automatic advance(output bit accepted);
        entry_t e;
        @(posedge clk);
        accepted = !curRst && !curStall;
        if (curRst) begin
            pendQ.delete();
        end else begin
            if (pendQ.size() > 0) begin
                e = pendQ.pop_front();
                modelMem[e.idx] = e.data;
                memKnown[e.idx] = 1'b1;
            end
            if (accepted && curMwo) begin
                pendQ.push_back('{idx: wordOf(curAo), data: curWo});
                $display("t=%0t store ODD  word %0d <= 0x%08h", $time, wordOf(curAo), curWo);
            end
            if (accepted && curMwe) begin
                pendQ.push_back('{idx: wordOf(curAe), data: curWe});
                $display("t=%0t store EVEN word %0d <= 0x%08h", $time, wordOf(curAe), curWe);
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input bit rst,
                        input bit mwo, input logic [31:0] ao, input logic [31:0] wo,
                        input bit mwe, input logic [31:0] ae, input logic [31:0] we);
        bit acc;
        applyAndCheck(rst, mwo, ao, wo, mwe, ae, we);
        advance(acc);
    endtask

    // Present a store pair until accepted, as a stalled processor would.
    task automatic storePair(input bit mwo, input logic [31:0] ao, input logic [31:0] wo,
                             input bit mwe, input logic [31:0] ae, input logic [31:0] we,
                             output int tries);
        bit acc;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            applyAndCheck(1'b0, mwo, ao, wo, mwe, ae, we);
            advance(acc);
            tries++;
        end
        if (!acc) checkVal("store_accept_timeout", 32'(tries), 32'(0));
    endtask

    task automatic idle(input int n, input logic [31:0] ao, input logic [31:0] ae);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ao, '0, 1'b0, ae, '0);
    endtask

    task automatic sweep();
        for (int w = 0; w < DW; w += 2) step(1'b0, 1'b0, 32'(w * 4), '0, 1'b0, 32'((w + 1) * 4), '0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int          tries;
        bit          acc;
        logic [31:0] d0, d1, ao, ae;

        for (int i = 0; i < DW; i++) begin
            memKnown[i] = 1'b0;
            modelMem[i] = '0;
        end

        reset = 1'b1; memwriteODD = 1'b0; dataadrODD = '0; writedataODD = '0;
        memwriteEVEN = 1'b0; dataadrEVEN = '0; writedataEVEN = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst_sb_count", 32'(sb_count), 32'(0));
        checkVal("rst_sb_empty", {31'b0, sb_empty}, 32'(1));
        checkVal("rst_stall",    {31'b0, stall},    32'(0));

        // Preload every word so later loads have a known expected value.
        for (int w = 0; w < DW; w += 2) begin
            d0 = (w == 12) ? 32'h0 : $urandom;
            d1 = $urandom;
            storePair(1'b1, 32'(w * 4), d0, 1'b1, 32'((w + 1) * 4), d1, tries);
        end
        idle(6, 32'h0, 32'h4);

        // Same-cycle ODD store forwarded to EVEN load only.
        applyAndCheck(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 32'h30, '0);
        checkVal("t4_even_fwd", readdataEVEN, 32'hCAFEF00D);
        checkVal("t4_odd_ram",  readdataODD,  32'h0);
        advance(acc);
        idle(3, 32'h30, 32'h30);

        // Single ODD store, visible through buffer then RAM.
        storePair(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, '0, tries);
        applyAndCheck(1'b0, 1'b0, 32'h10, '0, 1'b0, 32'h10, '0);
        checkVal("t1_cnt1", 32'(sb_count), 32'(1));
        checkVal("t1_rd1",  readdataODD, 32'hDEADBEEF);
        advance(acc);
        applyAndCheck(1'b0, 1'b0, 32'h10, '0, 1'b0, 32'h10, '0);
        checkVal("t1_cnt0", 32'(sb_count), 32'(0));
        checkVal("t1_rd0",  readdataODD, 32'hDEADBEEF);
        advance(acc);

        // Same-word pair: EVEN data must win.
        storePair(1'b1, 32'h20, 32'h1111, 1'b1, 32'h20, 32'h2222, tries);
        applyAndCheck(1'b0, 1'b0, 32'h20, '0, 1'b0, 32'h20, '0);
        checkVal("t2_cnt2",   32'(sb_count), 32'(2));
        checkVal("t2_rd_odd", readdataODD, 32'h2222);
        advance(acc);
        idle(3, 32'h20, 32'h20);
        applyAndCheck(1'b0, 1'b0, 32'h20, '0, 1'b0, 32'h24, '0);
        checkVal("t2_ram", readdataODD, 32'h2222);
        advance(acc);

        // Back-to-back pairs into a 4-deep buffer: third pair is held once.
        storePair(1'b1, 32'h40, 32'hA0, 1'b1, 32'h44, 32'hA1, tries);
        checkVal("t3_cnt2", 32'(sb_count), 32'(2));
        storePair(1'b1, 32'h48, 32'hA2, 1'b1, 32'h4C, 32'hA3, tries);
        checkVal("t3_cnt3",  32'(sb_count), 32'(3));
        checkVal("t3_stall", {31'b0, stall}, 32'(1));
        storePair(1'b1, 32'h50, 32'hA4, 1'b1, 32'h54, 32'hA5, tries);
        checkVal("t3_tries", 32'(tries), 32'(2));
        idle(6, 32'h40, 32'h54);
        for (int w = 16; w < 22; w += 2) step(1'b0, 1'b0, 32'(w * 4), '0, 1'b0, 32'((w + 1) * 4), '0);

        // Reset with three entries pending: they must never reach RAM.
        storePair(1'b1, 32'h60, 32'hB0, 1'b1, 32'h64, 32'hB1, tries);
        storePair(1'b1, 32'h68, 32'hB2, 1'b1, 32'h6C, 32'hB3, tries);
        step(1'b1, 1'b0, 32'h64, '0, 1'b0, 32'h68, '0);
        applyAndCheck(1'b0, 1'b0, 32'h64, '0, 1'b0, 32'h68, '0);
        checkVal("t5_cnt",   32'(sb_count), 32'(0));
        checkVal("t5_stall", {31'b0, stall},    32'(0));
        checkVal("t5_empty", {31'b0, sb_empty}, 32'(1));
        advance(acc);
        idle(2, 32'h60, 32'h6C);

        // Ten single stores to distinct words: pointers wrap several times.
        for (int i = 0; i < 10; i++) storePair(1'b1, 32'((40 + i) * 4), $urandom, 1'b0, '0, '0, tries);
        idle(12, 32'h0, 32'h4);
        for (int i = 0; i < 10; i += 2) step(1'b0, 1'b0, 32'((40 + i) * 4), '0, 1'b0, 32'((41 + i) * 4), '0);
        sweep();

        // Randomized traffic: clustered words for collisions, random upper
        // bits for aliasing, occasional reset.
        for (int c = 0; c < 1500; c++) begin
            ao = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            ae = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, ao, $urandom,
                 $urandom_range(0, 1) == 1, ae, $urandom);
        end
        idle(6, 32'h0, 32'h4);
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
